// File: rtl/oam_dma_arbiter_if.sv
// rtl/oam_dma_arbiter_if.sv - CPU port, main bus, high bus and OAM write signals of the OAM DMA arbiter
interface oam_dma_arbiter_if;
  logic [15:0] cpu_mem_addr;
  logic        cpu_mem_enable;
  logic        cpu_mem_write;
  logic [7:0]  cpu_mem_data_out;
  logic [7:0]  cpu_mem_data_in;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic [7:0]  hi_addr;
  logic        hi_enable;
  logic        hi_write;
  logic [7:0]  hi_data_out;
  logic [7:0]  hi_data_in;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_write;
  logic        dma_active;

  modport slave (
    input  cpu_mem_addr, cpu_mem_enable, cpu_mem_write, cpu_mem_data_out,
    output cpu_mem_data_in,
    output bus_addr, bus_enable, bus_write, bus_data_out,
    input  bus_data_in,
    output hi_addr, hi_enable, hi_write, hi_data_out,
    input  hi_data_in,
    output oam_addr, oam_data, oam_write, dma_active
  );

  modport master (
    output cpu_mem_addr, cpu_mem_enable, cpu_mem_write, cpu_mem_data_out,
    input  cpu_mem_data_in,
    input  bus_addr, bus_enable, bus_write, bus_data_out,
    output bus_data_in,
    input  hi_addr, hi_enable, hi_write, hi_data_out,
    output hi_data_in,
    input  oam_addr, oam_data, oam_write, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - Game Boy OAM DMA sequencer and CPU/DMA bus arbiter
// Optional macro OAM_DMA_ECHO_MIRROR_EN folds sources E0-FF onto C0-DF.
module oam_dma_arbiter #(
  parameter int          OAM_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input logic           clk,
  input logic           reset,
  oam_dma_arbiter_if.slave ifc
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  state_t      state, state_next;
  logic [1:0]  t_cycle;
  logic [7:0]  idx, idx_next;
  logic [7:0]  src, src_eff;
  logic        t3, is_dma_reg, is_main, is_hi, dma_reg_wr, last_byte;

  assign t3         = (t_cycle == 2'd3);
  assign is_dma_reg = (ifc.cpu_mem_addr == DMA_REG_ADDR);
  assign is_main    = (ifc.cpu_mem_addr < 16'hFF00);
  assign is_hi      = !is_main && !is_dma_reg;
  assign dma_reg_wr = ifc.cpu_mem_enable && ifc.cpu_mem_write && is_dma_reg && t3;
  assign last_byte  = (idx == 8'(OAM_LEN - 1));

`ifdef OAM_DMA_ECHO_MIRROR_EN
  assign src_eff = (src >= 8'hE0) ? (src - 8'h20) : src;
`else
  assign src_eff = src;
`endif

  // t_cycle shares its reset with the CPU, so phase 3 is always the CPU's T3
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      t_cycle <= 2'd0;
      idx     <= 8'd0;
      src     <= 8'h00;
    end else begin
      state   <= state_next;
      t_cycle <= t_cycle + 2'd1;
      idx     <= idx_next;
      if (dma_reg_wr)
        src <= ifc.cpu_mem_data_out;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (t3) begin
      case (state)
        IDLE: begin
          if (dma_reg_wr) begin
            state_next = START;
            idx_next   = 8'd0;
          end
        end
        START: begin
          state_next = dma_reg_wr ? START : ACTIVE;
          idx_next   = 8'd0;
        end
        ACTIVE: begin
          if (dma_reg_wr) begin
            state_next = START;
            idx_next   = 8'd0;
          end else if (last_byte) begin
            state_next = IDLE;
            idx_next   = 8'd0;
          end else begin
            idx_next = idx + 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = 8'd0;
        end
      endcase
    end
  end

  // During ACTIVE the main bus belongs to the DMA; the CPU keeps the high bus and FF46
  always_comb begin
    ifc.dma_active   = (state != IDLE);
    ifc.oam_write    = (state == ACTIVE) && t3;
    ifc.oam_addr     = idx;
    ifc.oam_data     = ifc.bus_data_in;
    ifc.hi_addr      = ifc.cpu_mem_addr[7:0];
    ifc.hi_enable    = ifc.cpu_mem_enable && is_hi;
    ifc.hi_write     = ifc.cpu_mem_enable && ifc.cpu_mem_write && is_hi;
    ifc.hi_data_out  = ifc.cpu_mem_data_out;
    ifc.bus_data_out = ifc.cpu_mem_data_out;
    if (state == ACTIVE) begin
      ifc.bus_addr   = {src_eff, idx};
      ifc.bus_enable = 1'b1;
      ifc.bus_write  = 1'b0;
    end else begin
      ifc.bus_addr   = ifc.cpu_mem_addr;
      ifc.bus_enable = ifc.cpu_mem_enable && is_main;
      ifc.bus_write  = ifc.cpu_mem_enable && ifc.cpu_mem_write && is_main;
    end
    if (is_dma_reg)
      ifc.cpu_mem_data_in = src;
    else if (is_hi)
      ifc.cpu_mem_data_in = ifc.hi_data_in;
    else if (state == ACTIVE)
      ifc.cpu_mem_data_in = 8'hFF;
    else
      ifc.cpu_mem_data_in = ifc.bus_data_in;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  oam_dma_arbiter_if ifc();

  oam_dma_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  // main bus returns addr low byte ^ 5A; high bus returns a fixed byte
  assign ifc.bus_data_in = ifc.bus_addr[7:0] ^ 8'h5A;
  assign ifc.hi_data_in  = 8'hA7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         oam_cnt;
  logic [7:0] oam_mem [0:255];
  always @(posedge clk) begin
    if (ifc.oam_write === 1'b1) begin
      oam_mem[ifc.oam_addr] = ifc.oam_data;
      oam_cnt = oam_cnt + 1;
    end
  end

  logic        c_dma_active, c_oam_write, c_bus_enable, c_bus_write, c_hi_enable, c_hi_write;
  logic [7:0]  c_oam_addr, c_oam_data, c_hi_addr, c_hi_data_out, c_cpu_rd;
  logic [15:0] c_bus_addr;

  // one M-cycle: drive at T0, capture at T3, return just after the commit edge
  task automatic mcyc(input logic [15:0] a, input logic en, input logic wr, input logic [7:0] d);
    ifc.cpu_mem_addr     = a;
    ifc.cpu_mem_enable   = en;
    ifc.cpu_mem_write    = wr;
    ifc.cpu_mem_data_out = d;
    repeat (3) @(posedge clk);
    #1;
    c_dma_active  = ifc.dma_active;
    c_oam_write   = ifc.oam_write;
    c_oam_addr    = ifc.oam_addr;
    c_oam_data    = ifc.oam_data;
    c_bus_addr    = ifc.bus_addr;
    c_bus_enable  = ifc.bus_enable;
    c_bus_write   = ifc.bus_write;
    c_hi_enable   = ifc.hi_enable;
    c_hi_write    = ifc.hi_write;
    c_hi_addr     = ifc.hi_addr;
    c_hi_data_out = ifc.hi_data_out;
    c_cpu_rd      = ifc.cpu_mem_data_in;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mcyc(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    ifc.cpu_mem_addr = 16'h0000; ifc.cpu_mem_enable = 1'b0;
    ifc.cpu_mem_write = 1'b0;    ifc.cpu_mem_data_out = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (ifc.dma_active !== 1'b0 || ifc.oam_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: dma_active=%b oam_write=%b required 0 0", ifc.dma_active, ifc.oam_write);
    end
    mcyc(16'hFF46, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_cpu_rd !== 8'h00 || c_hi_enable !== 1'b0 || c_bus_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ff46: rd=%h hi_en=%b bus_en=%b required 00 0 0", c_cpu_rd, c_hi_enable, c_bus_enable);
    end
    mcyc(16'h8012, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_bus_enable !== 1'b1 || c_bus_addr !== 16'h8012 || c_cpu_rd !== 8'h48 || c_hi_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_main_read: bus_en=%b addr=%h rd=%h hi_en=%b required 1 8012 48 0",
               c_bus_enable, c_bus_addr, c_cpu_rd, c_hi_enable);
    end
    mcyc(16'hFF80, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_hi_enable !== 1'b1 || c_hi_addr !== 8'h80 || c_bus_enable !== 1'b0 || c_cpu_rd !== 8'hA7) begin
      failures++;
      $display("FAIL reset_hi_read: hi_en=%b hi_addr=%h bus_en=%b rd=%h required 1 80 0 a7",
               c_hi_enable, c_hi_addr, c_bus_enable, c_cpu_rd);
    end
  endtask

  task automatic test_basic_transfer();
    logic       bad;
    logic [7:0] ei;
    oam_cnt = 0;
    mcyc(16'hFF46, 1'b1, 1'b1, 8'hC1);
    checks++;
    if (c_dma_active !== 1'b0) begin
      failures++;
      $display("FAIL basic_write_cycle: dma_active=%b required 0", c_dma_active);
    end
    idle();
    checks++;
    if (c_dma_active !== 1'b1 || c_oam_write !== 1'b0) begin
      failures++;
      $display("FAIL basic_start: dma_active=%b oam_write=%b required 1 0", c_dma_active, c_oam_write);
    end
    bad = 1'b0;
    for (int i = 0; i < 160; i++) begin
      ei = 8'(i);
      idle();
      if (!bad && (c_oam_write !== 1'b1 || c_oam_addr !== ei || c_oam_data !== (ei ^ 8'h5A)
                   || c_bus_addr !== {8'hC1, ei} || c_dma_active !== 1'b1)) begin
        bad = 1'b1;
        $display("FAIL basic_byte: i=%0d we=%b addr=%h data=%h bus=%h required 1 %h %h %h",
                 i, c_oam_write, c_oam_addr, c_oam_data, c_bus_addr, ei, ei ^ 8'h5A, {8'hC1, ei});
      end
    end
    checks++;
    if (bad) failures++;
    idle();
    checks++;
    if (c_dma_active !== 1'b0 || c_oam_write !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: dma_active=%b oam_write=%b required 0 0", c_dma_active, c_oam_write);
    end
    bad = 1'b0;
    for (int i = 0; i < 160; i++) begin
      ei = 8'(i);
      if (oam_mem[i] !== (ei ^ 8'h5A)) bad = 1'b1;
    end
    checks++;
    if (oam_cnt != 160 || bad) begin
      failures++;
      $display("FAIL basic_scoreboard: count=%0d contents_bad=%b required 160 0", oam_cnt, bad);
    end
  endtask

  task automatic test_active_cpu();
    oam_cnt = 0;
    mcyc(16'hFF46, 1'b1, 1'b1, 8'hC1);
    idle();
    for (int i = 0; i < 5; i++) idle();
    mcyc(16'h8000, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_cpu_rd !== 8'hFF || c_bus_addr !== 16'hC105 || c_oam_write !== 1'b1) begin
      failures++;
      $display("FAIL active_main_read: rd=%h bus=%h we=%b required ff c105 1", c_cpu_rd, c_bus_addr, c_oam_write);
    end
    mcyc(16'hC000, 1'b1, 1'b1, 8'h12);
    checks++;
    if (c_bus_write !== 1'b0 || c_bus_enable !== 1'b1 || c_bus_addr !== 16'hC106) begin
      failures++;
      $display("FAIL active_main_write: bus_write=%b bus_en=%b bus=%h required 0 1 c106", c_bus_write, c_bus_enable, c_bus_addr);
    end
    mcyc(16'hFF80, 1'b1, 1'b1, 8'h33);
    checks++;
    if (c_hi_enable !== 1'b1 || c_hi_write !== 1'b1 || c_hi_addr !== 8'h80 || c_hi_data_out !== 8'h33
        || c_oam_addr !== 8'h07) begin
      failures++;
      $display("FAIL active_hi_write: en=%b we=%b addr=%h data=%h oam_addr=%h required 1 1 80 33 07",
               c_hi_enable, c_hi_write, c_hi_addr, c_hi_data_out, c_oam_addr);
    end
    mcyc(16'hFF80, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_hi_enable !== 1'b1 || c_hi_write !== 1'b0 || c_cpu_rd !== 8'hA7 || c_oam_addr !== 8'h08) begin
      failures++;
      $display("FAIL active_hi_read: en=%b we=%b rd=%h oam_addr=%h required 1 0 a7 08",
               c_hi_enable, c_hi_write, c_cpu_rd, c_oam_addr);
    end
    for (int i = 9; i < 160; i++) idle();
    idle();
    checks++;
    if (oam_cnt != 160 || c_dma_active !== 1'b0) begin
      failures++;
      $display("FAIL active_undisturbed: count=%0d dma_active=%b required 160 0", oam_cnt, c_dma_active);
    end
  endtask

  task automatic test_restart_and_reset();
    oam_cnt = 0;
    mcyc(16'hFF46, 1'b1, 1'b1, 8'hC1);
    idle();
    for (int i = 0; i < 80; i++) idle();
    mcyc(16'hFF46, 1'b1, 1'b1, 8'hD0);
    checks++;
    if (c_oam_write !== 1'b1 || c_oam_addr !== 8'h50 || c_oam_data !== 8'h0A) begin
      failures++;
      $display("FAIL restart_inflight: we=%b addr=%h data=%h required 1 50 0a", c_oam_write, c_oam_addr, c_oam_data);
    end
    mcyc(16'hFF46, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_oam_write !== 1'b0 || c_dma_active !== 1'b1 || c_cpu_rd !== 8'hD0) begin
      failures++;
      $display("FAIL restart_start: we=%b active=%b ff46=%h required 0 1 d0", c_oam_write, c_dma_active, c_cpu_rd);
    end
    idle();
    checks++;
    if (c_oam_write !== 1'b1 || c_oam_addr !== 8'h00 || c_bus_addr !== 16'hD000) begin
      failures++;
      $display("FAIL restart_first: we=%b addr=%h bus=%h required 1 00 d000", c_oam_write, c_oam_addr, c_bus_addr);
    end
    for (int i = 1; i < 50; i++) idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ifc.dma_active !== 1'b0 || ifc.oam_write !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: dma_active=%b oam_write=%b required 0 0", ifc.dma_active, ifc.oam_write);
    end
    reset = 1'b0;
    mcyc(16'hFF46, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_cpu_rd !== 8'h00) begin
      failures++;
      $display("FAIL midreset_src: ff46=%h required 00", c_cpu_rd);
    end
    mcyc(16'h8000, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_bus_enable !== 1'b1 || c_bus_addr !== 16'h8000 || c_cpu_rd !== 8'h5A || c_dma_active !== 1'b0) begin
      failures++;
      $display("FAIL midreset_main: bus_en=%b bus=%h rd=%h active=%b required 1 8000 5a 0",
               c_bus_enable, c_bus_addr, c_cpu_rd, c_dma_active);
    end
    for (int i = 0; i < 4; i++) idle();
    checks++;
    if (oam_cnt != 131) begin
      failures++;
      $display("FAIL midreset_count: oam writes=%0d required 131", oam_cnt);
    end
  endtask

  task automatic test_echo_source();
    logic        bad;
    logic [7:0]  ei;
    logic [7:0]  hi_exp;
`ifdef OAM_DMA_ECHO_MIRROR_EN
    hi_exp = 8'hC3;
`else
    hi_exp = 8'hE3;
`endif
    mcyc(16'hFF46, 1'b1, 1'b1, 8'hE3);
    mcyc(16'hFF46, 1'b1, 1'b0, 8'h00);
    checks++;
    if (c_cpu_rd !== 8'hE3) begin
      failures++;
      $display("FAIL echo_readback: ff46=%h required e3", c_cpu_rd);
    end
    bad = 1'b0;
    for (int i = 0; i < 160; i++) begin
      ei = 8'(i);
      idle();
      if (!bad && (c_bus_addr !== {hi_exp, ei} || c_oam_write !== 1'b1)) begin
        bad = 1'b1;
        $display("FAIL echo_bus_addr: i=%0d bus=%h we=%b required %h 1", i, c_bus_addr, c_oam_write, {hi_exp, ei});
      end
    end
    checks++;
    if (bad) failures++;
    idle();
    checks++;
    if (c_dma_active !== 1'b0) begin
      failures++;
      $display("FAIL echo_end: dma_active=%b required 0", c_dma_active);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    oam_cnt  = 0;
    reset    = 1'b1;
    test_reset();
    test_basic_transfer();
    test_active_cpu();
    test_restart_and_reset();
    test_echo_source();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
